// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared types and constants for the BF16 to FP32 stream converter
package bf16_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
      S_HI   = 2'd2
   } state_t;

   localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

   // bit positions inside fpcsr
   localparam int FLAG_NV = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

endpackage

// File: rtl/bf16_to_fp32_stream_if.sv
// rtl/bf16_to_fp32_stream_if.sv - input/output stream handshake bundle of the converter
interface bf16_to_fp32_stream_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_pair;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;

   modport master (
      output in_valid, in_data, in_pair, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_pair, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/bf16_to_fp32_cvt.sv
// rtl/bf16_to_fp32_cvt.sv - combinational BF16 to FP32 widening with exception flags
// BF16_SUBNORMAL_FTZ_EN: flush subnormal inputs to signed zero and raise underflow.
module bf16_to_fp32_cvt
   import bf16_pkg::*;
(
   input  logic [15:0] i_bf16,
   output logic [31:0] o_fp32,
   output logic [3:0]  o_flags
);

   logic w_exp_max;
   logic w_man_nz;

   assign w_exp_max = (i_bf16[14:7] == 8'hFF);
   assign w_man_nz  = (i_bf16[6:0] != 7'h00);

`ifdef BF16_SUBNORMAL_FTZ_EN
   logic w_exp_zero;
   assign w_exp_zero = (i_bf16[14:7] == 8'h00);
`endif

   always_comb begin
      o_flags = 4'h0;
      o_fp32  = {i_bf16, 16'h0000};
      // quiet bit clear means the NaN was signalling
      if (w_exp_max && w_man_nz) begin
         o_fp32           = FP32_QNAN;
         o_flags[FLAG_NV] = ~i_bf16[6];
      end
`ifdef BF16_SUBNORMAL_FTZ_EN
      else if (w_exp_zero && w_man_nz) begin
         o_fp32           = {i_bf16[15], 31'h0};
         o_flags[FLAG_UF] = 1'b1;
      end
`endif
      o_flags[FLAG_OF] = 1'b0;
      o_flags[FLAG_NX] = 1'b0;
   end

endmodule

// File: rtl/bf16_to_fp32_stream.sv
// rtl/bf16_to_fp32_stream.sv - captures one or two packed BF16 values and emits them as FP32 words
// BF16_SUBNORMAL_FTZ_EN selects flush-to-zero of subnormals in the converter.
module bf16_to_fp32_stream
   import bf16_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   bf16_to_fp32_stream_if.slave         strm,
   input  logic                         fpcsr_clr,
   output logic [3:0]                   fpcsr
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_word;
   logic        r_pair;
   logic [3:0]  r_fpcsr;

   logic        w_accept;
   logic        w_out_hs;
   logic        w_sel_hi;
   logic [15:0] w_cvt_in;
   logic [31:0] w_cvt_out;
   logic [3:0]  w_cvt_flags;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      strm.in_ready  = 1'b0;
      strm.out_valid = 1'b0;
      w_sel_hi       = 1'b0;
      case (r_state)
         S_IDLE: begin
            strm.in_ready = 1'b1;
            if (strm.in_valid) w_next = S_LO;
         end
         S_LO: begin
            strm.out_valid = 1'b1;
            if (strm.out_ready) w_next = r_pair ? S_HI : S_IDLE;
         end
         S_HI: begin
            strm.out_valid = 1'b1;
            w_sel_hi       = 1'b1;
            if (strm.out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && strm.in_valid;
   assign w_out_hs = strm.out_valid && strm.out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word <= 32'h0;
         r_pair <= 1'b0;
      end else if (w_accept) begin
         r_word <= strm.in_data;
         r_pair <= strm.in_pair;
      end
   end

   assign w_cvt_in = w_sel_hi ? r_word[31:16] : r_word[15:0];

   bf16_to_fp32_cvt u_cvt (
      .i_bf16  (w_cvt_in),
      .o_fp32  (w_cvt_out),
      .o_flags (w_cvt_flags)
   );

   // a flag raised by this cycle's handshake survives a simultaneous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_fpcsr <= 4'h0;
      else       r_fpcsr <= (fpcsr_clr ? 4'h0 : r_fpcsr) | (w_out_hs ? w_cvt_flags : 4'h0);
   end

   assign strm.out_data = w_cvt_out;
   assign fpcsr         = r_fpcsr;

endmodule

// File: tb/tb_bf16_to_fp32_stream.sv
// tb/tb_bf16_to_fp32_stream.sv - directed and randomized checks of bf16_to_fp32_stream against a reference model
module tb_bf16_to_fp32_stream;

   logic       clk;
   logic       reset;
   logic       fpcsr_clr;
   logic [3:0] fpcsr;

   int         n_vec;
   int         n_err;
   logic [3:0] exp_fpcsr;

   bf16_to_fp32_stream_if ifc ();

   bf16_to_fp32_stream dut (
      .clk       (clk),
      .reset     (reset),
      .strm      (ifc),
      .fpcsr_clr (fpcsr_clr),
      .fpcsr     (fpcsr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_cvt(input logic [15:0] x);
      int e;
      int m;
      e = int'(x[14:7]);
      m = int'(x[6:0]);
      if (e == 255 && m != 0) return 32'h7FC0_0000;
`ifdef BF16_SUBNORMAL_FTZ_EN
      if (e == 0 && m != 0) return {x[15], 31'h0};
`endif
      return {x, 16'h0000};
   endfunction

   function automatic logic [3:0] ref_flags(input logic [15:0] x);
      int e;
      int m;
      logic [3:0] f;
      e = int'(x[14:7]);
      m = int'(x[6:0]);
      f = 4'h0;
      if (e == 255 && m != 0 && m < 64) f[3] = 1'b1;
`ifdef BF16_SUBNORMAL_FTZ_EN
      if (e == 0 && m != 0) f[1] = 1'b1;
`endif
      return f;
   endfunction

   function automatic logic [15:0] rand_bf16();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 3))
         1: x[14:7] = 8'hFF;
         2: x[14:7] = 8'h00;
         default: ;
      endcase
      return x;
   endfunction

   // one accepted word: optional stall on the lo half, optional clear during the lo handshake
   task automatic do_word(input logic [31:0] d, input logic p, input int stall, input logic clr_hs);
      logic [15:0] x;
      chk("in_ready_idle", 32'(ifc.in_ready), 32'h1);
      ifc.in_valid = 1'b1;
      ifc.in_data  = d;
      ifc.in_pair  = p;
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid = 1'b0;
      ifc.in_data  = $urandom;
      ifc.in_pair  = 1'($urandom_range(0, 1));
      for (int h = 0; h < (p ? 2 : 1); h++) begin
         x = (h == 1) ? d[31:16] : d[15:0];
         chk("out_valid", 32'(ifc.out_valid), 32'h1);
         chk("out_data", ifc.out_data, ref_cvt(x));
         for (int s = 0; s < stall && h == 0; s++) begin
            chk("stall_in_ready", 32'(ifc.in_ready), 32'h0);
            @(negedge clk);
            chk("stall_valid", 32'(ifc.out_valid), 32'h1);
            chk("stall_data", ifc.out_data, ref_cvt(x));
         end
         ifc.out_ready = 1'b1;
         fpcsr_clr     = clr_hs && (h == 0);
         @(posedge clk);
         exp_fpcsr = (fpcsr_clr ? 4'h0 : exp_fpcsr) | ref_flags(x);
         @(negedge clk);
         ifc.out_ready = 1'b0;
         fpcsr_clr     = 1'b0;
      end
      chk("out_valid_done", 32'(ifc.out_valid), 32'h0);
      chk("fpcsr", 32'(fpcsr), 32'(exp_fpcsr));
   endtask

   initial begin
      n_vec         = 0;
      n_err         = 0;
      exp_fpcsr     = 4'h0;
      reset         = 1'b1;
      fpcsr_clr     = 1'b0;
      ifc.in_valid  = 1'b0;
      ifc.in_data   = 32'h0;
      ifc.in_pair   = 1'b0;
      ifc.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'h0);
      chk("rst_out_data", ifc.out_data, 32'h0);
      chk("rst_fpcsr", 32'(fpcsr), 32'h0);
      reset = 1'b0;
      @(negedge clk);

      do_word(32'h0000_3F80, 1'b0, 0, 1'b0);
      do_word(32'hC000_3F80, 1'b1, 0, 1'b0);
      do_word(32'h0000_FF81, 1'b0, 0, 1'b0);
      chk("snan_flag", 32'(fpcsr), 32'h8);
      do_word(32'h0000_4049, 1'b0, 0, 1'b0);
      chk("flag_sticky", 32'(fpcsr), 32'h8);
      fpcsr_clr = 1'b1;
      @(negedge clk);
      fpcsr_clr = 1'b0;
      exp_fpcsr = 4'h0;
      chk("flag_cleared", 32'(fpcsr), 32'h0);
      do_word(32'h0000_FF81, 1'b0, 0, 1'b1);
      chk("clr_vs_set", 32'(fpcsr), 32'h8);
      fpcsr_clr = 1'b1;
      @(negedge clk);
      fpcsr_clr = 1'b0;
      exp_fpcsr = 4'h0;
      do_word(32'h0000_8001, 1'b0, 0, 1'b0);
      do_word(32'h7FC1_0000, 1'b1, 5, 1'b0);
      do_word(32'hC000_3F80, 1'b1, 5, 1'b0);

      // reset while the hi half is pending
      do_word(32'h0000_FFA0, 1'b0, 0, 1'b0);
      ifc.in_valid = 1'b1;
      ifc.in_data  = 32'hC000_3F80;
      ifc.in_pair  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ifc.out_ready = 1'b0;
      chk("hi_before_rst", ifc.out_data, 32'hC000_0000);
      reset = 1'b1;
      #1;
      exp_fpcsr = 4'h0;
      chk("rst_hi_valid", 32'(ifc.out_valid), 32'h0);
      chk("rst_hi_data", ifc.out_data, 32'h0);
      chk("rst_hi_fpcsr", 32'(fpcsr), 32'h0);
      @(negedge clk);
      reset         = 1'b0;
      ifc.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("no_stale_hi", 32'(ifc.out_valid), 32'h0);
      end
      ifc.out_ready = 1'b0;

      for (int i = 0; i < 200; i++) begin
         do_word({rand_bf16(), rand_bf16()}, 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bf16_to_fp32_stream.md
BF16_TO_FP32_STREAM -- requirements
Module: bf16_to_fp32_stream

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on its rising edge.
REQ-002 SHALL have: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  input  1  in_data holds a word to accept.
REQ-004 SHALL have: in_ready  output  1  block can accept a word this cycle.
REQ-005 SHALL have: in_data  input  32  packed BF16 values; lo = [15:0], hi = [31:16].
REQ-006 SHALL have: in_pair  input  1  1 = both halves valid, 0 = lo only; sampled with in_data.
REQ-007 SHALL have: out_valid  output  1  out_data holds a converted FP32 value.
REQ-008 SHALL have: out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 SHALL have: out_data  output  32  FP32 result.
REQ-010 SHALL have: fpcsr  output  4  sticky flags: [3] invalid, [2] overflow, [1] underflow, [0] inexact.
REQ-011 SHALL have: fpcsr_clr  input  1  synchronous clear of all fpcsr bits.

Function
REQ-012 SHALL implement states S_IDLE, S_LO, S_HI; in_ready = 1 only in S_IDLE.
REQ-013 S_IDLE with in_valid=1: SHALL capture in_data and in_pair, then go to S_LO.
REQ-014 S_LO: SHALL drive out_valid=1 and out_data = cvt(lo). On out_ready=1: go to S_HI if captured pair=1, else S_IDLE.
REQ-015 S_HI: SHALL drive out_valid=1 and out_data = cvt(hi). On out_ready=1: go to S_IDLE.
REQ-016 Latency: SHALL assert out_valid exactly one cycle after the accept edge.
REQ-017 SHALL have no combinational path from in_* to out_* or in_ready.
REQ-018 While out_valid=1 and out_ready=0: out_data SHALL hold stable, and state SHALL NOT change.
REQ-019 cvt(x) for normal, zero or infinity: SHALL equal {x, 16'h0000}. This conversion is exact.
REQ-020 cvt(x) for NaN (exp=8'hFF, man!=0): SHALL be canonical 32'h7FC00000, sign discarded.
REQ-021 Signalling NaN (exp=8'hFF, man[6]=0, man!=0): SHALL set fpcsr[3] when it is presented and out_ready=1.
REQ-022 fpcsr[2] and fpcsr[0] SHALL remain 0; a widening conversion never overflows or rounds.
REQ-023 Flags SHALL update only on an output handshake (out_valid & out_ready), ORing into current state.
REQ-024 fpcsr_clr=1 SHALL zero fpcsr. If fpcsr_clr and a flag-raising handshake occur in the same cycle, the new flag SHALL be set (set wins).

Reset
REQ-025 reset SHALL immediately force: state=S_IDLE, out_valid=0, out_data=32'h0, fpcsr=4'h0, captured word=0.
REQ-026 reset mid-pair SHALL discard pending halves; no stale output SHALL appear after release.

Configuration
REQ-027 With BF16_SUBNORMAL_FTZ_EN defined: subnormal input (exp=0, man!=0) SHALL convert to {sign, 31'h0} and set fpcsr[1] on handshake.
REQ-028 Without BF16_SUBNORMAL_FTZ_EN: subnormal input SHALL convert per REQ-019 (exact), and fpcsr[1] SHALL stay 0.

Structure
REQ-029 Shared package bf16_pkg SHALL hold: state enum, FP32_QNAN=32'h7FC00000, flag index constants FLAG_NV/OF/UF/NX.
REQ-030 Conversion and flag generation SHALL live in combinational sub-module bf16_to_fp32_cvt (16-bit in; 32-bit out plus flags), instantiated once and muxed on lo/hi.

Verification
REQ-031 Single: in_data=32'h0000_3F80, in_pair=0 -> out_data 32'h3F800000 next cycle; in_ready returns 1 after handshake.
REQ-032 Pair: in_data=32'hC000_3F80, in_pair=1 -> out_data 32'h3F800000 then 32'hC0000000 on consecutive handshakes.
REQ-033 sNaN: lo=16'hFF81 -> out_data 32'h7FC00000, fpcsr=4'b1000. Flag persists until fpcsr_clr. Clear and sNaN in the same cycle -> flag stays 1.
REQ-034 Subnormal: lo=16'h8001 -> 32'h80000000 and fpcsr[1]=1 with macro; 32'h80010000 and fpcsr=0 without.
REQ-035 Backpressure: out_ready=0 for 5 cycles in S_LO -> out_data and out_valid held, in_ready=0. Also assert reset in S_HI -> out_valid=0, and no hi output after release.
